// File: rtl/cal_position_tracker.sv
// Multi-channel DC-comp / PGA-gain position tracker: lowest-set-bit encode,
// per-channel debounce, commit on change and single-entry valid/ready update.
module cal_position_tracker #(
    parameter int DC_W       = 7,
    parameter int PGA_W      = 4,
    parameter int NUM_CH     = 2,
    parameter int STABLE_CNT = 4,
    localparam int DC_PW     = (DC_W > 1) ? $clog2(DC_W) : 1,
    localparam int PGA_PW    = (PGA_W > 1) ? $clog2(PGA_W) : 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     smp_valid,
    output logic                     smp_ready,
    input  logic [CH_W-1:0]          smp_ch,
    input  logic [DC_W-1:0]          dc_comp,
    input  logic [PGA_W-1:0]         pga_gain,
    output logic                     upd_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          upd_ch,
    output logic [DC_PW-1:0]         upd_dc_pos,
    output logic [PGA_PW-1:0]        upd_pga_pos,
    output logic [NUM_CH*DC_PW-1:0]  dc_pos_all,
    output logic [NUM_CH*PGA_PW-1:0] pga_pos_all,
    output logic [NUM_CH-1:0]        pos_vld,
    output logic [NUM_CH-1:0]        err_zero,
    output logic                     err_ch
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [3:0]    STABLE_L = 4'(STABLE_CNT);

    function automatic logic [DC_PW-1:0] lsb_dc(input logic [DC_W-1:0] w);
        lsb_dc = '0;
        for (int i = DC_W - 1; i >= 0; i--)
            if (w[i]) lsb_dc = DC_PW'(i);
    endfunction

    function automatic logic [PGA_PW-1:0] lsb_pga(input logic [PGA_W-1:0] w);
        lsb_pga = '0;
        for (int i = PGA_W - 1; i >= 0; i--)
            if (w[i]) lsb_pga = PGA_PW'(i);
    endfunction

    logic [DC_PW-1:0]  cand_dc  [NUM_CH];
    logic [PGA_PW-1:0] cand_pga [NUM_CH];
    logic [DC_PW-1:0]  com_dc   [NUM_CH];
    logic [PGA_PW-1:0] com_pga  [NUM_CH];
    logic [3:0]        cnt      [NUM_CH];
    logic [NUM_CH-1:0] cand_vld;

    logic              accept;
    logic              ch_ok;
    logic              word_zero;
    logic              same;
    logic              commit;
    logic [3:0]        cnt_nxt;
    logic [DC_PW-1:0]  enc_dc;
    logic [PGA_PW-1:0] enc_pga;

    assign smp_ready = !upd_valid | out_ready;

    always_comb begin
        accept    = smp_valid & smp_ready;
        ch_ok     = ({1'b0, smp_ch} < NUM_CH_L);
        enc_dc    = lsb_dc(dc_comp);
        enc_pga   = lsb_pga(pga_gain);
        word_zero = (dc_comp == '0) || (pga_gain == '0);
        same      = 1'b0;
        cnt_nxt   = 4'd1;
        commit    = 1'b0;
        if (ch_ok) begin
            same = cand_vld[smp_ch] && (cand_dc[smp_ch] == enc_dc) &&
                   (cand_pga[smp_ch] == enc_pga);
            if (same)
                cnt_nxt = (cnt[smp_ch] < STABLE_L) ? cnt[smp_ch] + 4'd1 : cnt[smp_ch];
            // commit only on the cycle the count reaches the threshold, not while saturated
            commit = accept && !word_zero && (cnt_nxt == STABLE_L) &&
                     !(same && (cnt[smp_ch] == STABLE_L)) &&
                     (!pos_vld[smp_ch] || (com_dc[smp_ch] != enc_dc) ||
                      (com_pga[smp_ch] != enc_pga));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cand_dc[i]  <= '0;
                cand_pga[i] <= '0;
                com_dc[i]   <= '0;
                com_pga[i]  <= '0;
                cnt[i]      <= '0;
            end
            cand_vld    <= '0;
            pos_vld     <= '0;
            err_zero    <= '0;
            err_ch      <= 1'b0;
            upd_valid   <= 1'b0;
            upd_ch      <= '0;
            upd_dc_pos  <= '0;
            upd_pga_pos <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cand_dc[i]  <= '0;
                cand_pga[i] <= '0;
                com_dc[i]   <= '0;
                com_pga[i]  <= '0;
                cnt[i]      <= '0;
            end
            cand_vld    <= '0;
            pos_vld     <= '0;
            err_zero    <= '0;
            err_ch      <= 1'b0;
            upd_valid   <= 1'b0;
            upd_ch      <= '0;
            upd_dc_pos  <= '0;
            upd_pga_pos <= '0;
        end else begin
            if (accept) begin
                if (!ch_ok) begin
                    err_ch <= 1'b1;
                end else if (word_zero) begin
                    err_zero[smp_ch] <= 1'b1;
                    cand_vld[smp_ch] <= 1'b0;
                    cnt[smp_ch]      <= '0;
                end else begin
                    cand_dc[smp_ch]  <= enc_dc;
                    cand_pga[smp_ch] <= enc_pga;
                    cand_vld[smp_ch] <= 1'b1;
                    cnt[smp_ch]      <= cnt_nxt;
                    if (commit) begin
                        com_dc[smp_ch]  <= enc_dc;
                        com_pga[smp_ch] <= enc_pga;
                        pos_vld[smp_ch] <= 1'b1;
                    end
                end
            end
            if (commit) begin
                upd_valid   <= 1'b1;
                upd_ch      <= smp_ch;
                upd_dc_pos  <= enc_dc;
                upd_pga_pos <= enc_pga;
            end else if (upd_valid && out_ready) begin
                upd_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        dc_pos_all  = '0;
        pga_pos_all = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            dc_pos_all[i*DC_PW +: DC_PW]    = com_dc[i];
            pga_pos_all[i*PGA_PW +: PGA_PW] = com_pga[i];
        end
    end

endmodule
